// File: rtl/async_pkg.sv
// rtl/async_pkg.sv - shared rail indices, link protocol codes and source FSM states
package async_pkg;

  localparam int RAIL_NUM = 2;
  localparam int RAIL_F   = 0;
  localparam int RAIL_T   = 1;

  // Link protocol selectors, compared against the ENC parameter
  localparam logic [15:0] ENC_TP = "TP";
  localparam logic [15:0] ENC_FP = "FP";

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    RTZ       = 2'd2,
    WAIT_NACK = 2'd3
  } src_state_t;

endpackage

// File: rtl/ack_sync.sv
// rtl/ack_sync.sv - flop-chain synchronizer for the asynchronous sink ack
module ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_ff;

  // Shift the raw ack through the chain; the last stage is the only one used downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/mem_reg_src.sv
// rtl/mem_reg_src.sv - clocked dual-rail link source; MEM_REG_SRC_TIMEOUT_EN adds an ack-wait timeout
module mem_reg_src
  import async_pkg::*;
#(
  parameter logic [15:0] ENC         = ENC_TP,
  parameter int          WIDTH       = 1,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_vld,
  output logic                            in_rdy,
  input  logic [WIDTH-1:0]                in_data,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]  out,
  input  logic                            ack_i,
  output logic                            busy,
  output logic                            err
);

  localparam bit IS_FP = (ENC == ENC_FP);

  src_state_t                     state;
  src_state_t                     state_n;
  logic                           ack_s;
  logic                           accept;
  logic                           ack_done;
  logic                           spurious;
  logic                           to_hit;
  logic [WIDTH-1:0][RAIL_NUM-1:0] code;

  ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_i),
    .q   (ack_s)
  );

  assign accept = (state == IDLE) && in_vld && in_rdy;

  generate
    if (IS_FP) begin : g_fp
      // Return-to-zero code: each bit raises exactly one of its two rails from the all-zero spacer
      always_comb begin
        code = '0;
        for (int i = 0; i < WIDTH; i++) begin
          code[i][RAIL_T] = in_data[i];
          code[i][RAIL_F] = ~in_data[i];
        end
      end
      assign ack_done = ack_s;
      assign spurious = ack_s;
    end else begin : g_tp
      logic ack_prev;
      // Transition code: each bit flips the rail it selects relative to the current link level
      always_comb begin
        code = '0;
        for (int i = 0; i < WIDTH; i++) begin
          code[i][RAIL_T] = out[i][RAIL_T] ^ in_data[i];
          code[i][RAIL_F] = out[i][RAIL_F] ^ ~in_data[i];
        end
      end
      // Last seen ack level; tracking every cycle equals resampling on completion or spurious edge
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ack_prev <= 1'b0;
        end else begin
          ack_prev <= ack_s;
        end
      end
      assign ack_done = ack_s ^ ack_prev;
      assign spurious = ack_s ^ ack_prev;
    end
  endgenerate

  // Next-state decode; RTZ and WAIT_NACK are only reachable in the four-phase build
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (accept)   state_n = WAIT_ACK;
      WAIT_ACK:  if (ack_done) state_n = IS_FP ? RTZ : IDLE;
      RTZ:                     state_n = WAIT_NACK;
      WAIT_NACK: if (!ack_s)   state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

`ifdef MEM_REG_SRC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             entering;

  assign waiting  = (state == WAIT_ACK) || (state == WAIT_NACK);
  assign entering = (state_n != state) && ((state_n == WAIT_ACK) || (state_n == WAIT_NACK));
  assign to_hit   = waiting && (state_n == state) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Wait-cycle counter: cleared on entry to a wait state, saturates at TIMEOUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (entering) begin
      wait_cnt <= '0;
    end else if (waiting && (wait_cnt != CNT_W'(TIMEOUT))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  // No counter in this build; TIMEOUT is only meaningful with the counter present
  assign to_hit = (TIMEOUT < 0);
`endif

  // FSM, handshake flags and link drive; reset clears every rail at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      out    <= '0;
      in_rdy <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      in_rdy <= (state_n == IDLE);
      busy   <= (state_n != IDLE);
      if (accept) begin
        out <= code;
      end else if (IS_FP && (state == WAIT_ACK) && ack_done) begin
        out <= '0;
      end
      if (((state == IDLE) && spurious) || to_hit) begin
        err <= 1'b1;
      end
    end
  end

endmodule
